// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// transaction source, access sizes and the IO-window tag.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd3
    } size_e;

    localparam logic [1:0] IO_WINDOW = 2'b11;

    function automatic logic [2:0] size_to_len(input logic [1:0] sz);
        return {1'b0, sz} + 3'd1;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// onto an 8-bit RAM/IO port with one-cycle read latency and bus-grant stalls.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rstn_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_clr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    state_e      state_q, state_d;
    src_e        src_q, src_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic        pend_q, pend_d;
    logic        stall_q, stall_d;
    logic        io_q, io_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        cap_now;
    logic        abort;
    logic        issue;
    logic [2:0]  idx;

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_IF;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            pend_q     <= 1'b0;
            stall_q    <= 1'b0;
            io_q       <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            pend_q     <= pend_d;
            stall_q    <= stall_d;
            io_q       <= io_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // cnt_q counts bytes already captured (reads) or written (writes). A read
    // byte is outstanding (pend_q) for one cycle; if the grant dropped in that
    // cycle its data is gone, so the same index is issued again.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        pend_d     = pend_q;
        io_d       = io_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        stall_d    = ~rdy_in;
        mem_a      = '0;
        mem_wr     = 1'b0;
        mem_dout   = '0;
        cap_now    = 1'b0;
        abort      = 1'b0;
        issue      = 1'b0;
        idx        = '0;

        if (rdy_in) begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            pend_d    = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A requester still sees its done pulse this cycle, so its
                    // held request must not start a second transaction.
                    if (ls_req && !ls_done_q) begin
                        state_d = ls_wr ? ST_WRITE : ST_READ;
                        src_d   = SRC_LS;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        len_d   = size_to_len(ls_size);
                        io_d    = (ls_addr[RAM_ADDR_WIDTH -: 2] == IO_WINDOW);
                        cnt_d   = '0;
                        asm_d   = '0;
                    end else if (if_req && !if_done_q && !if_clr) begin
                        state_d = ST_READ;
                        src_d   = SRC_IF;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        len_d   = size_to_len(SZ_WORD);
                        io_d    = (if_addr[RAM_ADDR_WIDTH -: 2] == IO_WINDOW);
                        cnt_d   = '0;
                        asm_d   = '0;
                    end
                end
                ST_READ: begin
                    abort   = (src_q == SRC_IF) && if_clr;
                    cap_now = pend_q && !stall_q;
                    if (cap_now) begin
                        asm_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
                        cnt_d = cnt_q + 3'd1;
                    end
                    idx = cnt_q + {2'b00, cap_now};
                    // RAM reads may still issue into an abort cycle; IO reads
                    // have side effects and never do.
                    issue = (idx < len_q) && !(abort && io_q);
                    if (issue) begin
                        mem_a  = addr_q + {29'd0, idx};
                        pend_d = 1'b1;
                    end
                    if (abort) begin
                        state_d = ST_IDLE;
                        pend_d  = 1'b0;
                    end else if (cap_now && (cnt_d == len_q)) begin
                        state_d = ST_IDLE;
                        if (src_q == SRC_IF) begin
                            if_done_d = 1'b1;
                            if_data_d = asm_d;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = asm_d;
                        end
                    end
                end
                ST_WRITE: begin
                    mem_wr   = 1'b1;
                    mem_a    = addr_q + {29'd0, cnt_q};
                    mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_d == len_q) begin
                        state_d   = ST_IDLE;
                        ls_done_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized bench for mem_ctrl with a byte-addressed memory
// responder and a transaction-level reference model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rstn_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_clr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int total = 0;
    int bad   = 0;

    mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
        .clk_in   (clk_in),
        .rstn_in  (rstn_in),
        .rdy_in   (rdy_in),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_clr   (if_clr),
        .if_done  (if_done),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_wr    (ls_wr),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Memory environment: sparse RAM plus an IO port that returns a new byte
    // on every read, so duplicated or dropped IO reads show up in the data.
    logic [7:0] ram [bit [31:0]];
    logic [7:0] io_byte  = 8'h41;
    int         io_reads = 0;

    function automatic bit is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk_in) begin
        if (!rdy_in) begin
            mem_din <= 8'hA5;
        end else if (mem_wr) begin
            ram[mem_a] = mem_dout;
        end else if (is_io(mem_a)) begin
            mem_din <= io_byte;
            io_byte = io_byte + 8'd1;
            io_reads++;
        end else begin
            mem_din <= ram_rd(mem_a);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction from one requester. Without a stall the bus schedule is
    // checked cycle by cycle: byte k at cycle k+1, done at N+2 (read) / N+1 (write).
    task automatic do_txn(input bit ls, input bit wr_in, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int st_c, input int st_len);
        int          n;
        int          nio;
        int          io0;
        int          done_c;
        bit          wr;
        bit          got;
        logic [7:0]  eb [4];
        logic [31:0] exp_w;
        logic [31:0] other_hold;
        logic [31:0] ak;
        logic        done_bit;
        logic        other_done;
        wr    = ls && wr_in;
        n     = ls ? int'(sz) + 1 : 4;
        nio   = 0;
        exp_w = '0;
        for (int k = 0; k < 4; k++) eb[k] = 8'h00;
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            if (wr) eb[k] = wd[8*k +: 8];
            else if (is_io(ak)) begin
                eb[k] = io_byte + 8'(nio);
                nio++;
            end else eb[k] = ram_rd(ak);
            exp_w[8*k +: 8] = eb[k];
        end
        io0        = io_reads;
        other_hold = ls ? if_data : ls_rdata;
        if (ls) begin
            ls_req = 1'b1; ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        got    = 1'b0;
        done_c = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk_in);
            done_bit   = ls ? ls_done : if_done;
            other_done = ls ? if_done : ls_done;
            chk("stray_done", {31'd0, other_done}, 32'd0);
            if (!rdy_in) chk("stall_wr", {31'd0, mem_wr}, 32'd0);
            if (st_len == 0) begin
                if (c <= n) begin
                    chk(wr ? "wr_addr" : "rd_addr", mem_a, a + c - 1);
                    chk("wr_flag", {31'd0, mem_wr}, {31'd0, wr});
                    if (wr) chk("wr_byte", {24'd0, mem_dout}, {24'd0, eb[c-1]});
                end else if (c == n + 1) begin
                    chk("gap_addr", mem_a, 32'd0);
                    chk("gap_wr", {31'd0, mem_wr}, 32'd0);
                end
            end
            if (done_bit) begin
                got    = 1'b1;
                done_c = c;
            end else if (st_len > 0) begin
                if (c == st_c) rdy_in = 1'b0;
                if (c == st_c + st_len) rdy_in = 1'b1;
            end
        end
        rdy_in = 1'b1;
        chk("done_seen", {31'd0, got}, 32'd1);
        if (st_len == 0) chk("done_cycle", done_c, wr ? n + 1 : n + 2);
        if (ls) ls_req = 1'b0; else if_req = 1'b0;
        if (!wr) chk("rdata", ls ? ls_rdata : if_data, exp_w);
        else for (int k = 0; k < n; k++) chk("ram_byte", {24'd0, ram_rd(a + k)}, {24'd0, eb[k]});
        if (st_len == 0) chk("io_issues", io_reads - io0, nio);
        chk("other_hold", ls ? if_data : ls_rdata, other_hold);
        @(negedge clk_in);
        chk("done_pulse", {31'd0, ls ? ls_done : if_done}, 32'd0);
        chk("no_restart", mem_a, 32'd0);
        $display("txn %s %s size=%0d addr=%h wdata=%h stall=%0d@%0d done_c=%0d exp=%h",
                 ls ? "LS" : "IF", wr ? "WR" : "RD", n, a, wd, st_len, st_c, done_c, exp_w);
    endtask

    logic [31:0] wd_fix;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [1:0]  r_sz;
    bit          r_ls;
    bit          r_wr;
    bit          any_io;
    bit          pgot;
    int          r_n;
    int          r_stc;
    int          r_stl;
    int          pdc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_in = 1'b0; rdy_in = 1'b1;
        if_req = 1'b0; if_addr = '0; if_clr = 1'b0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00;
        ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        repeat (2) @(negedge clk_in);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rstn_in = 1'b1;
        @(negedge clk_in);

        // Basic fetch
        do_txn(1'b0, 1'b0, 2'd0, 32'h1000, 32'd0, 0, 0);
        chk("fetch_word", if_data, 32'h0000_0013);

        // LS wins over a simultaneous fetch; the fetch starts right after
        wd_fix   = 32'hDEAD_BEEF;
        ls_req   = 1'b1; ls_wr = 1'b1; ls_size = 2'd3; ls_addr = 32'h2000; ls_wdata = wd_fix;
        if_req   = 1'b1; if_addr = 32'h1000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_in);
            chk("pri_wr", {31'd0, mem_wr}, 32'd1);
            chk("pri_addr", mem_a, 32'h2000 + c - 1);
            chk("pri_dout", {24'd0, mem_dout}, {24'd0, wd_fix[8*(c-1) +: 8]});
        end
        @(negedge clk_in);
        chk("pri_ls_done", {31'd0, ls_done}, 32'd1);
        chk("pri_gap", mem_a, 32'd0);
        ls_req = 1'b0;
        @(negedge clk_in);
        chk("pri_fetch_start", mem_a, 32'h1000);
        chk("pri_ls_pulse", {31'd0, ls_done}, 32'd0);
        pgot = 1'b0; pdc = 0;
        for (int c = 7; c <= 30 && !pgot; c++) begin
            @(negedge clk_in);
            if (if_done) begin pgot = 1'b1; pdc = c; end
        end
        chk("pri_if_cycle", pdc, 11);
        chk("pri_if_data", if_data, 32'h0000_0013);
        if_req = 1'b0;
        for (int k = 0; k < 4; k++) chk("pri_ram", {24'd0, ram_rd(32'h2000 + k)}, {24'd0, wd_fix[8*k +: 8]});
        $display("txn priority LS-store then IF-fetch if_done_cycle=%0d", pdc);
        @(negedge clk_in);

        // IO byte load and stalled fetch
        do_txn(1'b1, 1'b0, 2'd0, 32'h0003_0000, 32'd0, 0, 0);
        do_txn(1'b0, 1'b0, 2'd0, 32'h1000, 32'd0, 3, 3);
        chk("stall_same_word", if_data, 32'h0000_0013);

        // if_clr together with the request: nothing starts
        if_req = 1'b1; if_clr = 1'b1; if_addr = 32'h1000;
        @(negedge clk_in);
        chk("clr_accept_addr", mem_a, 32'd0);
        if_req = 1'b0; if_clr = 1'b0;
        @(negedge clk_in);
        chk("clr_accept_done", {31'd0, if_done}, 32'd0);
        $display("txn IF clr-at-accept");

        // if_clr in cycle 2 of a fetch, then an immediate load
        if_req = 1'b1; if_addr = 32'h1000;
        @(negedge clk_in);
        chk("clr_c1_addr", mem_a, 32'h1000);
        @(negedge clk_in);
        chk("clr_c2_addr", mem_a, 32'h1001);
        if_clr = 1'b1;
        @(negedge clk_in);
        chk("clr_idle_addr", mem_a, 32'd0);
        chk("clr_no_done", {31'd0, if_done}, 32'd0);
        if_req = 1'b0; if_clr = 1'b0;
        $display("txn IF clr-in-cycle-2");
        do_txn(1'b1, 1'b0, 2'd0, 32'h4000, 32'd0, 0, 0);

        // Address wrap
        do_txn(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 0);
        do_txn(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'd0, 0, 0);

        // Randomized mix
        for (int t = 0; t < 40; t++) begin
            r_ls = ($urandom % 2) == 1;
            r_wr = r_ls && (($urandom % 2) == 1);
            case ($urandom % 3)
                0: r_sz = 2'd0;
                1: r_sz = 2'd1;
                default: r_sz = 2'd3;
            endcase
            r_n    = r_ls ? int'(r_sz) + 1 : 4;
            r_addr = $urandom;
            if (($urandom % 5) == 0) r_addr = 32'hFFFF_FFFC + ($urandom % 4);
            r_wd   = $urandom;
            any_io = 1'b0;
            for (int k = 0; k < r_n; k++) if (is_io(r_addr + k)) any_io = 1'b1;
            r_stc = 1 + int'($urandom % 4);
            r_stl = (!any_io && (($urandom % 3) == 0)) ? 1 + int'($urandom % 3) : 0;
            do_txn(r_ls, r_wr, r_sz, r_addr, r_wd, r_stc, r_stl);
        end

        // Reset in the middle of a store
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd3; ls_addr = 32'h5000; ls_wdata = 32'h1122_3344;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("mid_wr_active", {31'd0, mem_wr}, 32'd1);
        rstn_in = 1'b0;
        #1;
        chk("rst_wr_now", {31'd0, mem_wr}, 32'd0);
        chk("rst_addr_now", mem_a, 32'd0);
        chk("rst_if_data_now", if_data, 32'd0);
        chk("rst_ls_rdata_now", ls_rdata, 32'd0);
        ls_req = 1'b0;
        @(negedge clk_in);
        rstn_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            chk("post_rst_done", {31'd0, ls_done}, 32'd0);
            chk("post_rst_wr", {31'd0, mem_wr}, 32'd0);
        end
        $display("txn reset mid-store");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 17, the RAM address width; the IO window is where address bits [RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] equal 2'b11.
REQ-002 SHALL have ports:
- clk_in  in  1  sole clock, rising edge.
- rstn_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  bus grant; low means the debug host owns memory and the block freezes.
- mem_din  in  8  byte returned by RAM/IO, valid one cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write.
- if_req  in  1  instruction-fetch request, held until if_done or if_clr.
- if_addr  in  32  fetch address.
- if_clr  in  1  abort the fetch (pipeline flush).
- if_done  out  1  one-cycle pulse; if_data is valid.
- if_data  out  32  fetched word, little-endian.
- ls_req  in  1  load/store request, held until ls_done.
- ls_wr  in  1  1 = store.
- ls_size  in  2  byte count minus 1; legal values 0, 1, 3.
- ls_addr  in  32  data address.
- ls_wdata  in  32  store data, byte 0 in [7:0].
- ls_done  out  1  one-cycle pulse.
- ls_rdata  out  32  load data, zero-extended.

Function
REQ-003 SHALL implement the FSM states IDLE, READ and WRITE, with a source register {IF, LS}, a byte counter and a 32-bit assembly register.
REQ-004 In IDLE with rdy_in=1, SHALL accept ls_req over if_req when both are high; a pending if_req waits.
REQ-005 SHALL treat a fetch as a 4-byte read; a load as a (ls_size+1)-byte read; a store as a (ls_size+1)-byte write.
REQ-006 Read of N bytes accepted in cycle 0:
- mem_a = A+k in cycles 1..N.
- mem_din captured into byte k in cycle k+2.
- Done pulses in cycle N+2.
- Then return to IDLE.
REQ-007 Write of N bytes accepted in cycle 0:
- mem_wr=1, mem_a=A+k, mem_dout=wdata byte k in cycles 1..N.
- ls_done pulses in cycle N+1.
REQ-008 Address arithmetic SHALL be 32-bit and wrap modulo 2^32 without a fault.
REQ-009 In IDLE, and in any cycle not issuing a byte, SHALL drive mem_wr=0, mem_a=0 and mem_dout=0.
REQ-010 While rdy_in=0:
- Hold state, counter, assembly register and done outputs.
- Force mem_wr=0.
- Suppress capture.
- Any byte whose capture cycle fell in the stall SHALL be re-addressed after rdy_in returns high, so that no byte is lost or duplicated in the result.
REQ-011 When if_clr=1 during a fetch (including the accept cycle), SHALL abort next edge to IDLE with no if_done; if_clr SHALL have no effect on LS transactions.
REQ-012 When if_clr and if_req are both high in IDLE, SHALL NOT start a fetch.
REQ-013 if_data and ls_rdata SHALL hold their last value until the next done of the same port.
REQ-014 IO-window reads SHALL each be issued exactly once when rdy_in stays high.

Reset
REQ-015 While rstn_in=0:
- FSM SHALL be IDLE.
- mem_a, mem_dout, mem_wr, if_done, ls_done, if_data and ls_rdata SHALL all be 0.
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction immediately; no done pulse SHALL follow deassertion.

Structure
REQ-017 A shared package SHALL hold:
- FSM state encodings.
- Source encodings.
- Size encodings.
- IO-window constant 2'b11.
REQ-018 SHALL be a single module, no sub-module.

Verification
REQ-019 The bench SHALL cover:
- Fetch A=0x1000 with RAM bytes 13,00,00,00 -> mem_a 0x1000..0x1003 in cycles 1-4; if_done in cycle 6; if_data=0x00000013.
- ls_req store size 3, A=0x2000, wdata 0xDEADBEEF, with if_req high -> LS first; writes EF,BE,AD,DE; ls_done in cycle 5; fetch starts next.
- Byte load at 0x30000 (IO), rdy_in high -> exactly one issue of 0x30000; ls_rdata=0x000000xx.
- rdy_in low for 3 cycles during cycle 3 of a 4-byte read -> same if_data as the unstalled run; mem_wr stays 0.
- if_clr in cycle 2 of a fetch -> no if_done; IDLE next cycle; a following ls_req is accepted immediately.
- rstn_in low mid-write -> mem_wr=0 immediately; no ls_done after release.
